rate_monitor: RTL and testbench
===============================

# rate_monitor

Receive-side checker for the output of the rate limiter. It observes a sampled 6-bit stream together with the target that stream is slewing toward, and flags every sample-to-sample step larger than `step_size`. It reports settle latency and peak step magnitude, and keeps a saturating violation count. It sits downstream of the limiter (or any slew-limited source) and is used in-system and as a bench scoreboard.

## Interface
- `DATA_W`, 6: sample/target width (unsigned)
- `STEP_W`, 3: step_size width
- `CNT_W`, 8: width of violation and settle counters

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset (asserted when 0)
- `sample_valid` in 1: `sample` is valid this cycle
- `sample` in DATA_W: observed stream value
- `target` in DATA_W: value the stream is slewing toward
- `step_size` in STEP_W: max allowed |Δ| between consecutive valid samples
- `clear` in 1: synchronous clear of state and statistics
- `violation` out 1: one-cycle pulse, last sample broke the slew rule
- `violation_count` out CNT_W: saturating count of violations
- `settled` out 1: level, stream currently equals target
- `settle_done` out 1: one-cycle pulse on TRACK→SETTLED
- `settle_cycles` out CNT_W: valid samples taken by the last completed settle
- `max_delta` out DATA_W: largest |Δ| seen since reset/clear

## Operation
- States: IDLE (no previous sample), TRACK (slewing), SETTLED.
- Internal regs: `prev` (last valid sample), `tgt_q` (target latched at TRACK entry), `run_cnt`.
- Only cycles with `sample_valid`=1 advance state; other cycles hold everything except the pulse outputs, which return to 0.
- IDLE + valid:
  - `prev`←sample, `tgt_q`←target, no Δ check.
  - If sample==target: go to SETTLED, `settled`=1, no `settle_done`.
  - Otherwise: go to TRACK, `run_cnt`←0.
- TRACK/SETTLED + valid:
  - Δ = |sample − prev|, computed at DATA_W+1 bits, no wrap.
  - `max_delta`←max(`max_delta`, Δ).
  - Δ > step_size (zero-extended) sets `violation` and increments `violation_count`, which saturates at 2^CNT_W−1.
  - `step_size`=0: any change is a violation.
  - `prev`←sample.
- TRACK + valid:
  - `run_cnt`←`run_cnt`+1, saturating.
  - If sample==`tgt_q`: go to SETTLED, `settle_done`=1, `settle_cycles`←`run_cnt`+1 (saturating), `settled`=1.
  - If target≠`tgt_q`: `tgt_q`←target and `run_cnt` restarts at 1. The current sample is still compared against the new target.
- SETTLED + valid:
  - If target≠`tgt_q` or sample≠target: go to TRACK, `tgt_q`←target, `run_cnt`←1, `settled`=0.
  - If sample already equals the new target: stay in SETTLED, update `tgt_q`, no `settle_done`.
- `clear`=1:
  - Go to IDLE and zero every output and counter.
  - Any sample on the same cycle is discarded.
  - `clear` has priority over `sample_valid`.
- A violation never changes state; the monitor keeps tracking.

## Timing
- All outputs are registered. The response to a valid sample at edge N is visible after edge N, i.e. 1-cycle latency.
- Reset (`reset`=0, asynchronous): state IDLE; all outputs 0; `prev`, `tgt_q`, `run_cnt` = 0.
- Reset release is synchronous to the design's first edge. The first valid sample after release is treated as the IDLE case.
- Reset asserted mid-TRACK aborts immediately. No `settle_done` is produced and the statistics are lost.
- `violation` and `settle_done` can pulse on the same cycle, e.g. an oversized final step onto the target.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.

## Test plan
- Reset/idle: hold `reset`=0 with random inputs, then release with `sample_valid`=0. All outputs stay 0 and state is IDLE.
- Clean ramp: target=32, step_size=7, samples 0,7,14,21,28,32.
  - No `violation`.
  - `settle_done` pulses once after sample 32; `settle_cycles`=5; `max_delta`=7; `settled`=1.
- Oversized step: step_size=7, samples 0,7,20.
  - `violation` pulses exactly once, one cycle after 20; `violation_count`=1; `max_delta`=13.
- Retarget: settled at 32, then target=15 with samples 25,18,15.
  - `settled` drops after 25, `settle_done` fires after 15, `settle_cycles`=3, no violation.
- Saturation/zero step: CNT_W=2, step_size=0, alternate samples 0,1 six times.
  - `violation_count` stops at 3 and `violation` keeps pulsing.
- Clear priority: assert `clear` and `sample_valid` together mid-TRACK, then feed sample=target.
  - All outputs zero after the clear.
  - The next sample is handled as IDLE: `settled`=1, no `settle_done`.

Source files
------------

// File: rtl/rate_monitor.sv
// Slew-rate checker for a sampled stream: flags steps larger than step_size, tracks settle
// latency toward a target, peak step magnitude and a saturating violation count.
module rate_monitor #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned STEP_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] target,
  input  logic [STEP_W-1:0] step_size,
  input  logic              clear,
  output logic              violation,
  output logic [CNT_W-1:0]  violation_count,
  output logic              settled,
  output logic              settle_done,
  output logic [CNT_W-1:0]  settle_cycles,
  output logic [DATA_W-1:0] max_delta
);

  typedef enum logic [1:0] {StIdle, StTrack, StSettled} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                violation_q, violation_d;
  logic [CNT_W-1:0]    vcount_q, vcount_d;
  logic                settled_q, settled_d;
  logic                settle_done_q, settle_done_d;
  logic [CNT_W-1:0]    settle_cycles_q, settle_cycles_d;
  logic [DATA_W-1:0]   max_delta_q, max_delta_d;

  logic [DATA_W-1:0]   delta;
  logic                step_viol;
  logic [CNT_W-1:0]    run_inc;
  logic [CNT_W-1:0]    vcount_inc;

  // Unsigned inputs, so the magnitude always fits in DATA_W bits without wrap.
  assign delta      = (sample >= prev_q) ? sample - prev_q : prev_q - sample;
  assign step_viol  = {{STEP_W{1'b0}}, delta} > {{DATA_W{1'b0}}, step_size};
  assign run_inc    = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);
  assign vcount_inc = (vcount_q == '1) ? vcount_q : vcount_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      prev_q          <= '0;
      tgt_q           <= '0;
      run_cnt_q       <= '0;
      violation_q     <= 1'b0;
      vcount_q        <= '0;
      settled_q       <= 1'b0;
      settle_done_q   <= 1'b0;
      settle_cycles_q <= '0;
      max_delta_q     <= '0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      tgt_q           <= tgt_d;
      run_cnt_q       <= run_cnt_d;
      violation_q     <= violation_d;
      vcount_q        <= vcount_d;
      settled_q       <= settled_d;
      settle_done_q   <= settle_done_d;
      settle_cycles_q <= settle_cycles_d;
      max_delta_q     <= max_delta_d;
    end
  end

  // Outside IDLE, target always equals tgt_q after a retarget, so the live target decides.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else if (sample_valid) begin
      unique case (state_q)
        StIdle:    state_d = (sample == target) ? StSettled : StTrack;
        StTrack:   if (sample == target) state_d = StSettled;
        StSettled: if (sample != target) state_d = StTrack;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    prev_d          = prev_q;
    tgt_d           = tgt_q;
    run_cnt_d       = run_cnt_q;
    violation_d     = 1'b0;
    vcount_d        = vcount_q;
    settled_d       = settled_q;
    settle_done_d   = 1'b0;
    settle_cycles_d = settle_cycles_q;
    max_delta_d     = max_delta_q;
    if (clear) begin
      prev_d          = '0;
      tgt_d           = '0;
      run_cnt_d       = '0;
      vcount_d        = '0;
      settled_d       = 1'b0;
      settle_cycles_d = '0;
      max_delta_d     = '0;
    end else if (sample_valid) begin
      prev_d = sample;
      tgt_d  = target;
      if (state_q == StIdle) begin
        run_cnt_d = '0;
        settled_d = (sample == target);
      end else begin
        if (delta > max_delta_q) max_delta_d = delta;
        if (step_viol) begin
          violation_d = 1'b1;
          vcount_d    = vcount_inc;
        end
        if (state_q == StTrack) begin
          run_cnt_d = (target != tgt_q) ? CNT_W'(1) : run_inc;
          if (sample == target) begin
            settle_done_d   = 1'b1;
            settle_cycles_d = run_cnt_d;
            settled_d       = 1'b1;
          end
        end else if (sample != target) begin
          run_cnt_d = CNT_W'(1);
          settled_d = 1'b0;
        end
      end
    end
  end

  assign violation       = violation_q;
  assign violation_count = vcount_q;
  assign settled         = settled_q;
  assign settle_done     = settle_done_q;
  assign settle_cycles   = settle_cycles_q;
  assign max_delta       = max_delta_q;

endmodule

// File: tb/tb_rate_monitor.sv
// Directed bench for rate_monitor; a second instance with CNT_W=2 covers counter saturation.
module tb_rate_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [5:0] sample;
  logic [5:0] target;
  logic [2:0] step_size;
  logic       clear;

  logic       violation, settled, settle_done;
  logic [7:0] violation_count, settle_cycles;
  logic [5:0] max_delta;

  logic       violation_s, settled_s, settle_done_s;
  logic [1:0] violation_count_s, settle_cycles_s;
  logic [5:0] max_delta_s;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rate_monitor #(.DATA_W(6), .STEP_W(3), .CNT_W(8)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .sample_valid    (sample_valid),
    .sample          (sample),
    .target          (target),
    .step_size       (step_size),
    .clear           (clear),
    .violation       (violation),
    .violation_count (violation_count),
    .settled         (settled),
    .settle_done     (settle_done),
    .settle_cycles   (settle_cycles),
    .max_delta       (max_delta)
  );

  rate_monitor #(.DATA_W(6), .STEP_W(3), .CNT_W(2)) u_sat (
    .clk             (clk),
    .reset           (reset),
    .sample_valid    (sample_valid),
    .sample          (sample),
    .target          (target),
    .step_size       (step_size),
    .clear           (clear),
    .violation       (violation_s),
    .violation_count (violation_count_s),
    .settled         (settled_s),
    .settle_done     (settle_done_s),
    .settle_cycles   (settle_cycles_s),
    .max_delta       (max_delta_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_viol"},  32'(violation), 0);
    check({tag, "_vcnt"},  32'(violation_count), 0);
    check({tag, "_settl"}, 32'(settled), 0);
    check({tag, "_sdone"}, 32'(settle_done), 0);
    check({tag, "_scyc"},  32'(settle_cycles), 0);
    check({tag, "_maxd"},  32'(max_delta), 0);
  endtask

  task automatic cyc(input logic v, input logic [5:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ramp [5];

  initial begin
    ramp = '{6'd0, 6'd7, 6'd14, 6'd21, 6'd28};
    reset = 1'b0;
    clear = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    target = '0;
    step_size = '0;

    // Reset held with random inputs, then released idle
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'($urandom);
      sample       = 6'($urandom);
      target       = 6'($urandom);
      step_size    = 3'($urandom);
      clear        = 1'($urandom);
      @(posedge clk);
      #1;
      check_zero("in_reset");
    end
    sample_valid = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    cyc(1'b0, 6'd9);
    cyc(1'b0, 6'd9);
    check_zero("post_reset");

    // Clean ramp to 32
    target = 6'd32;
    step_size = 3'd7;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, ramp[i]);
      check("ramp_viol", 32'(violation), 0);
      check("ramp_sdone", 32'(settle_done), 0);
      check("ramp_settl", 32'(settled), 0);
    end
    cyc(1'b1, 6'd32);
    check("ramp_end_sdone", 32'(settle_done), 1);
    check("ramp_end_scyc", 32'(settle_cycles), 5);
    check("ramp_end_maxd", 32'(max_delta), 7);
    check("ramp_end_settl", 32'(settled), 1);
    check("ramp_end_vcnt", 32'(violation_count), 0);
    cyc(1'b0, 6'd0);
    check("ramp_hold_sdone", 32'(settle_done), 0);
    check("ramp_hold_settl", 32'(settled), 1);

    // Retarget from settled 32 down to 15
    target = 6'd15;
    cyc(1'b1, 6'd25);
    check("rt_25_settl", 32'(settled), 0);
    check("rt_25_viol", 32'(violation), 0);
    cyc(1'b1, 6'd18);
    check("rt_18_sdone", 32'(settle_done), 0);
    cyc(1'b1, 6'd15);
    check("rt_15_sdone", 32'(settle_done), 1);
    check("rt_15_scyc", 32'(settle_cycles), 3);
    check("rt_15_settl", 32'(settled), 1);
    check("rt_15_vcnt", 32'(violation_count), 0);

    // Oversized step 7 -> 20
    clear = 1'b1;
    cyc(1'b0, 6'd0);
    clear = 1'b0;
    check_zero("clr1");
    target = 6'd40;
    cyc(1'b1, 6'd0);
    check("big_0_viol", 32'(violation), 0);
    cyc(1'b1, 6'd7);
    check("big_7_viol", 32'(violation), 0);
    cyc(1'b1, 6'd20);
    check("big_20_viol", 32'(violation), 1);
    check("big_20_vcnt", 32'(violation_count), 1);
    check("big_20_maxd", 32'(max_delta), 13);
    check("big_20_settl", 32'(settled), 0);
    cyc(1'b0, 6'd0);
    check("big_hold_viol", 32'(violation), 0);
    check("big_hold_vcnt", 32'(violation_count), 1);

    // Clear together with a valid sample mid-track
    clear = 1'b1;
    cyc(1'b1, 6'd40);
    clear = 1'b0;
    check_zero("clr_prio");
    cyc(1'b1, 6'd40);
    check("clr_next_settl", 32'(settled), 1);
    check("clr_next_sdone", 32'(settle_done), 0);
    check("clr_next_maxd", 32'(max_delta), 0);

    // Oversized final step onto the target: both pulses together
    clear = 1'b1;
    cyc(1'b0, 6'd0);
    clear = 1'b0;
    target = 6'd10;
    cyc(1'b1, 6'd0);
    cyc(1'b1, 6'd10);
    check("both_viol", 32'(violation), 1);
    check("both_sdone", 32'(settle_done), 1);
    check("both_scyc", 32'(settle_cycles), 1);
    check("both_maxd", 32'(max_delta), 10);

    // Asynchronous reset mid-track
    target = 6'd50;
    cyc(1'b1, 6'd0);
    cyc(1'b1, 6'd5);
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 reset = 1'b1;

    // Saturation with step_size 0 on the CNT_W=2 instance
    clear = 1'b1;
    cyc(1'b0, 6'd0);
    clear = 1'b0;
    step_size = 3'd0;
    target = 6'd63;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 6'(i % 2));
      check("sat_viol", 32'(violation_s), (i == 0) ? 0 : 1);
      check("sat_vcnt", 32'(violation_count_s), (i > 3) ? 3 : i);
    end
    cyc(1'b1, 6'd1);
    check("sat_same_viol", 32'(violation_s), 0);
    check("sat_same_vcnt", 32'(violation_count_s), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
